// File: rtl/psum_acc_sequencer.sv
// psum_acc_sequencer: walks every output pixel of every output tile and reads
// the KI_DIM^2 partial sums of its conv window from pmem. It drives the SFU
// clear/accumulate strobes and hands each finished sum to a consumer.
// Optional feature macro: PSUM_ACC_STALL_CNT_EN adds a saturating stall_cnt
// output that counts cycles with out_valid high and out_ready low.
//
// Handshake: a result transfers on a rising edge where out_valid && out_ready.
// out_valid stays high, and onij_idx/otile_idx stay stable, until that edge.
module psum_acc_sequencer #(
  parameter int KI_DIM       = 3,
  parameter int A_PAD_NI_DIM = 6,
  parameter int STRIDE       = 1,
  parameter int N_OTILE      = 1,
  parameter int ADDR_W       = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              CEN_pmem,
  output logic              WEN_pmem,
  output logic [ADDR_W-1:0] A_pmem,
  output logic              acc,
  output logic              sfu_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        onij_idx,
  output logic [7:0]        otile_idx,
`ifdef PSUM_ACC_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [2:0]        state_dbg
);

  localparam int KK       = KI_DIM * KI_DIM;
  localparam int LEN_NIJ  = A_PAD_NI_DIM * A_PAD_NI_DIM;
  localparam int O_NI_DIM = (A_PAD_NI_DIM - KI_DIM) / STRIDE + 1;
  localparam int SW       = ADDR_W + 2;

  typedef logic [SW-1:0] sum_t;

  // Constant steps: moving one kx also moves one kij slice, moving one ky
  // moves one padded row plus KI_DIM kij slices.
  localparam sum_t COL_STEP  = sum_t'(1 + LEN_NIJ);
  localparam sum_t ROW_STEP  = sum_t'(A_PAD_NI_DIM + KI_DIM * LEN_NIJ);
  localparam sum_t OX_STEP   = sum_t'(STRIDE);
  localparam sum_t OY_STEP   = sum_t'(STRIDE * A_PAD_NI_DIM);
  localparam sum_t TILE_STEP = sum_t'(KK * LEN_NIJ);

  localparam logic [7:0] K_LAST = 8'(KI_DIM - 1);
  localparam logic [7:0] O_LAST = 8'(O_NI_DIM - 1);
  localparam logic [7:0] T_LAST = 8'(N_OTILE - 1);

  if (N_OTILE * KK * LEN_NIJ > 2 ** ADDR_W) begin : g_addr_chk
    $error("psum_acc_sequencer: psum regions exceed the pmem address space");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RD   = 3'd2,
    S_TAIL = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] kx, ky, ox, oy;
  sum_t       tile_base, row_base, pix_base, win_row, cur_addr;
  sum_t       nxt_addr;
  logic       rd_last, pix_last;

  assign state_dbg = state;

  // Next window address and end-of-window / end-of-sweep detection.
  always_comb begin
    rd_last  = (kx == K_LAST) && (ky == K_LAST);
    pix_last = (ox == O_LAST) && (oy == O_LAST) && (otile_idx == T_LAST);
    if (kx == K_LAST) nxt_addr = win_row + ROW_STEP;
    else              nxt_addr = cur_addr + COL_STEP;
  end

  // Sequencer FSM with registered outputs and incremental address counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      CEN_pmem  <= 1'b1;
      WEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      acc       <= 1'b0;
      sfu_clr   <= 1'b0;
      out_valid <= 1'b0;
      onij_idx  <= '0;
      otile_idx <= '0;
      kx        <= '0;
      ky        <= '0;
      ox        <= '0;
      oy        <= '0;
      tile_base <= '0;
      row_base  <= '0;
      pix_base  <= '0;
      win_row   <= '0;
      cur_addr  <= '0;
    end else begin
      WEN_pmem <= 1'b1;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_CLR;
            busy      <= 1'b1;
            sfu_clr   <= 1'b1;
            kx        <= '0;
            ky        <= '0;
            ox        <= '0;
            oy        <= '0;
            onij_idx  <= '0;
            otile_idx <= '0;
            tile_base <= '0;
            row_base  <= '0;
            pix_base  <= '0;
          end
        end
        S_CLR: begin
          sfu_clr  <= 1'b0;
          CEN_pmem <= 1'b0;
          kx       <= '0;
          ky       <= '0;
          cur_addr <= pix_base;
          win_row  <= pix_base;
          A_pmem   <= pix_base[ADDR_W-1:0];
          state    <= S_RD;
        end
        S_RD: begin
          // pmem data lags the address by one cycle, so acc trails CEN.
          acc <= 1'b1;
          if (rd_last) begin
            CEN_pmem <= 1'b1;
            state    <= S_TAIL;
          end else begin
            cur_addr <= nxt_addr;
            A_pmem   <= nxt_addr[ADDR_W-1:0];
            if (kx == K_LAST) begin
              kx      <= '0;
              ky      <= ky + 8'd1;
              win_row <= nxt_addr;
            end else begin
              kx <= kx + 8'd1;
            end
          end
        end
        S_TAIL: begin
          acc       <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pix_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              sfu_clr <= 1'b1;
              state   <= S_CLR;
              if (ox != O_LAST) begin
                ox       <= ox + 8'd1;
                onij_idx <= onij_idx + 8'd1;
                pix_base <= pix_base + OX_STEP;
              end else if (oy != O_LAST) begin
                ox       <= '0;
                oy       <= oy + 8'd1;
                onij_idx <= onij_idx + 8'd1;
                row_base <= row_base + OY_STEP;
                pix_base <= row_base + OY_STEP;
              end else begin
                ox        <= '0;
                oy        <= '0;
                onij_idx  <= '0;
                otile_idx <= otile_idx + 8'd1;
                tile_base <= tile_base + TILE_STEP;
                row_base  <= tile_base + TILE_STEP;
                pix_base  <= tile_base + TILE_STEP;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PSUM_ACC_STALL_CNT_EN
  // Saturating count of consumer back-pressure cycles for the current sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 stall_cnt <= '0;
    else if (state == S_IDLE && start)          stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                                                stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Testbench for psum_acc_sequencer: one default-parameter instance and one
// instance with KI_DIM=3, A_PAD_NI_DIM=7, STRIDE=2, N_OTILE=2.
module tb_psum_acc_sequencer;

  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic          start = 1'b0, out_ready = 1'b1;
  logic          busy, done, CEN_pmem, WEN_pmem, acc, sfu_clr, out_valid;
  logic [AW-1:0] A_pmem;
  logic [7:0]    onij_idx, otile_idx;
  logic [2:0]    state_dbg;
`ifdef PSUM_ACC_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  psum_acc_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem), .acc(acc),
    .sfu_clr(sfu_clr), .out_valid(out_valid), .out_ready(out_ready),
    .onij_idx(onij_idx), .otile_idx(otile_idx),
`ifdef PSUM_ACC_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- DUT B (strided, two tiles) ----------------
  logic          start4 = 1'b0, ready4 = 1'b1;
  logic          busy4, done4, cen4, wen4, acc4, clr4, valid4;
  logic [AW-1:0] a4;
  logic [7:0]    onij4, otile4;
  logic [2:0]    state_dbg4;
`ifdef PSUM_ACC_STALL_CNT_EN
  logic [15:0]   stall_cnt4;
`endif

  psum_acc_sequencer #(.KI_DIM(3), .A_PAD_NI_DIM(7), .STRIDE(2), .N_OTILE(2)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .CEN_pmem(cen4), .WEN_pmem(wen4), .A_pmem(a4), .acc(acc4),
    .sfu_clr(clr4), .out_valid(valid4), .out_ready(ready4),
    .onij_idx(onij4), .otile_idx(otile4),
`ifdef PSUM_ACC_STALL_CNT_EN
    .stall_cnt(stall_cnt4),
`endif
    .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [AW-1:0] exp_q[$];
  int            pix_q[$];
  int            cap_a[16][9];
  int            cap_b[18][9];

  typedef struct {
    int dut;
    int pix;
    int j;
    int exp_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: every read address of a sweep, straight from the conv formula.
  task automatic build_model(input int k, input int a, input int s, input int nt);
    int o, len;
    o = (a - k) / s + 1;
    len = a * a;
    exp_q.delete();
    pix_q.delete();
    for (int t = 0; t < nt; t++)
      for (int oy = 0; oy < o; oy++)
        for (int ox = 0; ox < o; ox++) begin
          pix_q.push_back(t * 256 + oy * o + ox);
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              exp_q.push_back(AW'(t * k * k * len + (oy * s + ky) * a + ox * s + kx
                                  + (ky * k + kx) * len));
        end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cen"}, CEN_pmem, 1);
    check({tag, "_wen"}, WEN_pmem, 1);
    check({tag, "_addr"}, A_pmem, 0);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_clr"}, sfu_clr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_onij"}, onij_idx, 0);
    check({tag, "_otile"}, otile_idx, 0);
`ifdef PSUM_ACC_STALL_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  // Full sweep on DUT A with optional stall, random ready, and stray starts.
  task automatic sweep_a(input int stall_pix, input int stall_len, input bit rand_rdy,
                         input bit poke_start);
    int cyc, pix, rd_cnt, acc_cnt, clr_cnt, stall_run, stalls_total, exp_pix, held;
    bit got_done, in_out;
    logic [AW-1:0] ea;
    build_model(3, 6, 1, 1);
    cyc = 0; pix = 0; rd_cnt = 0; acc_cnt = 0; clr_cnt = 0;
    stall_run = 0; stalls_total = 0; exp_pix = 0; held = 0;
    got_done = 0; in_out = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    while (!got_done && cyc < 4000) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && cyc == 40) start = 1'b1;
      if (cyc == 0) check("busy_after_start", busy, 1);
      if (!CEN_pmem) begin
        if (exp_q.size() == 0) check("extra_read", 1, 0);
        else begin
          ea = exp_q.pop_front();
          check("rd_addr", A_pmem, ea);
        end
        if (pix < 16 && rd_cnt < 9) cap_a[pix][rd_cnt] = int'(A_pmem);
        rd_cnt++;
      end
      if (acc) acc_cnt++;
      if (sfu_clr) clr_cnt++;
      if (out_valid) begin
        if (!in_out) begin
          in_out = 1;
          exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : -1;
          held = int'(A_pmem);
          check("reads_per_pixel", rd_cnt, 9);
          check("acc_per_pixel", acc_cnt, 9);
          check("clr_per_pixel", clr_cnt, 1);
        end else begin
          check("stall_cen", CEN_pmem, 1);
          check("stall_addr_held", A_pmem, held);
        end
        check("out_acc_low", acc, 0);
        check("onij_idx", onij_idx, exp_pix % 256);
        check("otile_idx", otile_idx, exp_pix / 256);
        if (pix == stall_pix && stall_run < stall_len) out_ready = 1'b0;
        else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        else out_ready = 1'b1;
        if (!out_ready) begin
          stall_run++;
          stalls_total++;
        end else begin
          pix++; rd_cnt = 0; acc_cnt = 0; clr_cnt = 0; stall_run = 0; in_out = 0;
        end
      end
      if (done) begin
        got_done = 1;
        check("done_cycle", cyc, 16 * 12 + stalls_total);
        check("pixels_done", pix, 16);
        if (poke_start) start = 1'b1;
      end
      cyc++;
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("reads_left", exp_q.size(), 0);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
    @(negedge clk);
    check("no_restart_busy", busy, 0);
    check("no_restart_clr", sfu_clr, 0);
`ifdef PSUM_ACC_STALL_CNT_EN
    check("stall_cnt_at_done", stall_cnt, stalls_total);
`endif
  endtask

  // Full sweep on DUT B with ready held high.
  task automatic sweep_b();
    int cyc, pix, rd_cnt, ep;
    bit got_done;
    logic [AW-1:0] ea;
    build_model(3, 7, 2, 2);
    cyc = 0; pix = 0; rd_cnt = 0; got_done = 0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    while (!got_done && cyc < 4000) begin
      @(negedge clk);
      start4 = 1'b0;
      if (!cen4) begin
        if (exp_q.size() == 0) check("b_extra_read", 1, 0);
        else begin
          ea = exp_q.pop_front();
          check("b_rd_addr", a4, ea);
        end
        if (pix < 18 && rd_cnt < 9) cap_b[pix][rd_cnt] = int'(a4);
        rd_cnt++;
      end
      if (valid4) begin
        ep = (pix_q.size() > 0) ? pix_q.pop_front() : -1;
        check("b_onij_idx", onij4, ep % 256);
        check("b_otile_idx", otile4, ep / 256);
        check("b_reads_per_pixel", rd_cnt, 9);
        pix++;
        rd_cnt = 0;
      end
      if (done4) begin
        got_done = 1;
        check("b_done_cycle", cyc, 18 * 12);
      end
      cyc++;
    end
    if (!got_done) check("b_done_timeout", 0, 1);
    check("b_reads_left", exp_q.size(), 0);
    @(negedge clk);
    check("b_busy_after_done", busy4, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Known addresses from hand calculation of the conv address formula.
    vecs.push_back('{0, 0, 0, 0});   vecs.push_back('{0, 0, 1, 37});
    vecs.push_back('{0, 0, 2, 74});  vecs.push_back('{0, 0, 3, 114});
    vecs.push_back('{0, 0, 4, 151}); vecs.push_back('{0, 0, 5, 188});
    vecs.push_back('{0, 0, 6, 228}); vecs.push_back('{0, 0, 7, 265});
    vecs.push_back('{0, 0, 8, 302});
    vecs.push_back('{0, 5, 0, 7});   vecs.push_back('{0, 5, 1, 44});
    vecs.push_back('{0, 5, 2, 81});  vecs.push_back('{0, 5, 3, 121});
    vecs.push_back('{0, 5, 4, 158}); vecs.push_back('{0, 5, 5, 195});
    vecs.push_back('{0, 5, 6, 235}); vecs.push_back('{0, 5, 7, 272});
    vecs.push_back('{0, 5, 8, 309}); vecs.push_back('{0, 15, 8, 323});
    vecs.push_back('{1, 9, 0, 441}); vecs.push_back('{1, 8, 0, 32});
    vecs.push_back('{1, 17, 0, 473});
    for (int p = 0; p < 16; p++) for (int j = 0; j < 9; j++) cap_a[p][j] = -1;
    for (int p = 0; p < 18; p++) for (int j = 0; j < 9; j++) cap_b[p][j] = -1;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Clean sweep, then a 5-cycle stall at pixel 3.
    sweep_a(-1, 0, 0, 0);
    sweep_a(3, 5, 0, 0);
    // Random consumer back-pressure.
    sweep_a(-1, 0, 1, 0);
    sweep_a(-1, 0, 1, 0);
    // Stray start while busy and on the done cycle.
    sweep_a(-1, 0, 0, 1);

    // Reset mid-sweep during the reads of pixel 2.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_reading", CEN_pmem, 0);
    check("pre_reset_onij", onij_idx, 2);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;
    check_reset_vals("midrst_hold");
    sweep_a(-1, 0, 0, 0);

    // Strided two-tile instance.
    sweep_b();

    // Table of known addresses against captured reads.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut == 0)
        check($sformatf("tbl_a_p%0d_j%0d", vecs[i].pix, vecs[i].j),
              cap_a[vecs[i].pix][vecs[i].j], vecs[i].exp_addr);
      else
        check($sformatf("tbl_b_p%0d_j%0d", vecs[i].pix, vecs[i].j),
              cap_b[vecs[i].pix][vecs[i].j], vecs[i].exp_addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
